// File: rtl/sdram_bist.sv
// Write-then-read pattern BIST that drives the request port of sdram_core_32bit.
// Define SDRAM_BIST_LFSR_EN for a Galois LFSR pattern; otherwise the pattern is address ^ SEED.
module sdram_bist #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 1024,
  parameter logic [31:0] SEED      = 32'hA5A5_5A5A
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] fail_addr_o,
  output logic [31:0] fail_data_o,
  output logic [3:0]  outport_wr_o,
  output logic        outport_rd_o,
  output logic [7:0]  outport_len_o,
  output logic [31:0] outport_addr_o,
  output logic [31:0] outport_write_data_o,
  input  logic        outport_accept_i,
  input  logic        outport_ack_i,
  input  logic        outport_error_i,
  input  logic [31:0] outport_read_data_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_ACK = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_ACK = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 32'd1);

`ifdef SDRAM_BIST_LFSR_EN
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
  endfunction
`endif

  state_t      state_r, state_n;
  logic [31:0] cnt_r, cnt_n;
  logic [3:0]  wr_r, wr_n;
  logic        rd_r, rd_n;
  logic [31:0] addr_r, addr_n;
  logic [31:0] wdata_r, wdata_n;
  logic        busy_r, busy_n;
  logic        done_r, done_n;
  logic        pass_r, pass_n;
  logic [15:0] err_r, err_n;
  logic [31:0] faddr_r, faddr_n;
  logic [31:0] fdata_r, fdata_n;
`ifdef SDRAM_BIST_LFSR_EN
  logic [31:0] pat_r, pat_n;
  logic [31:0] exp_r, exp_n;
`endif

  logic        last_s;
  logic [31:0] next_addr_s;
  logic [31:0] first_pat_s;
  logic [31:0] next_pat_s;
  logic [31:0] exp_s;
  logic        rd_bad_s;
  logic        first_err_s;
  logic [15:0] err_inc_s;

  assign last_s      = (cnt_r == LAST_IDX);
  assign next_addr_s = addr_r + 32'd4;
  assign first_err_s = (err_r == 16'h0000);
  assign err_inc_s   = (err_r == 16'hFFFF) ? err_r : err_r + 16'd1;
`ifdef SDRAM_BIST_LFSR_EN
  // pat_r already holds the next word's value because it advances on acceptance
  assign first_pat_s = SEED_EFF;
  assign next_pat_s  = pat_r;
  assign exp_s       = exp_r;
`else
  assign first_pat_s = BASE_ADDR ^ SEED;
  assign next_pat_s  = next_addr_s ^ SEED;
  assign exp_s       = addr_r ^ SEED;
`endif
  assign rd_bad_s = outport_error_i | (outport_read_data_i != exp_s);

  // Next-state and next-register values for the whole test sequencer
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    wr_n    = wr_r;
    rd_n    = rd_r;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    busy_n  = busy_r;
    done_n  = done_r;
    pass_n  = pass_r;
    err_n   = err_r;
    faddr_n = faddr_r;
    fdata_n = fdata_r;
`ifdef SDRAM_BIST_LFSR_EN
    pat_n   = pat_r;
    exp_n   = exp_r;
`endif
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_n = S_WR_REQ;
          cnt_n   = 32'h0;
          wr_n    = 4'hF;
          rd_n    = 1'b0;
          addr_n  = BASE_ADDR;
          wdata_n = first_pat_s;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = 16'h0000;
          faddr_n = 32'h0;
          fdata_n = 32'h0;
`ifdef SDRAM_BIST_LFSR_EN
          pat_n   = SEED_EFF;
`endif
        end else begin
          state_n = state_r;
        end
      end
      S_WR_REQ: begin
        if (outport_accept_i) begin
          state_n = S_WR_ACK;
          wr_n    = 4'h0;
`ifdef SDRAM_BIST_LFSR_EN
          pat_n   = lfsr_next(pat_r);
`endif
        end else begin
          state_n = state_r;
        end
      end
      S_WR_ACK: begin
        if (outport_ack_i) begin
          if (outport_error_i) begin
            err_n   = err_inc_s;
            faddr_n = first_err_s ? addr_r : faddr_r;
            fdata_n = first_err_s ? 32'h0 : fdata_r;
          end else begin
            err_n   = err_r;
          end
          if (last_s) begin
            state_n = S_RD_REQ;
            cnt_n   = 32'h0;
            rd_n    = 1'b1;
            addr_n  = BASE_ADDR;
            wdata_n = 32'h0;
`ifdef SDRAM_BIST_LFSR_EN
            pat_n   = SEED_EFF;
`endif
          end else begin
            state_n = S_WR_REQ;
            cnt_n   = cnt_r + 32'd1;
            wr_n    = 4'hF;
            addr_n  = next_addr_s;
            wdata_n = next_pat_s;
          end
        end else begin
          state_n = state_r;
        end
      end
      S_RD_REQ: begin
        if (outport_accept_i) begin
          state_n = S_RD_ACK;
          rd_n    = 1'b0;
`ifdef SDRAM_BIST_LFSR_EN
          exp_n   = pat_r;
          pat_n   = lfsr_next(pat_r);
`endif
        end else begin
          state_n = state_r;
        end
      end
      S_RD_ACK: begin
        if (outport_ack_i) begin
          if (rd_bad_s) begin
            err_n   = err_inc_s;
            faddr_n = first_err_s ? addr_r : faddr_r;
            fdata_n = first_err_s ? outport_read_data_i : fdata_r;
          end else begin
            err_n   = err_r;
          end
          if (last_s) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = rd_bad_s ? 1'b0 : first_err_s;
          end else begin
            state_n = S_RD_REQ;
            cnt_n   = cnt_r + 32'd1;
            rd_n    = 1'b1;
            addr_n  = next_addr_s;
          end
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        state_n = S_IDLE;
        wr_n    = 4'h0;
        rd_n    = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
      cnt_r   <= 32'h0;
      wr_r    <= 4'h0;
      rd_r    <= 1'b0;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= 16'h0000;
      faddr_r <= 32'h0;
      fdata_r <= 32'h0;
`ifdef SDRAM_BIST_LFSR_EN
      pat_r   <= 32'h0;
      exp_r   <= 32'h0;
`endif
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      wr_r    <= wr_n;
      rd_r    <= rd_n;
      addr_r  <= addr_n;
      wdata_r <= wdata_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      pass_r  <= pass_n;
      err_r   <= err_n;
      faddr_r <= faddr_n;
      fdata_r <= fdata_n;
`ifdef SDRAM_BIST_LFSR_EN
      pat_r   <= pat_n;
      exp_r   <= exp_n;
`endif
    end
  end

  assign busy_o               = busy_r;
  assign done_o               = done_r;
  assign pass_o               = pass_r;
  assign err_count_o          = err_r;
  assign fail_addr_o          = faddr_r;
  assign fail_data_o          = fdata_r;
  assign outport_wr_o         = wr_r;
  assign outport_rd_o         = rd_r;
  assign outport_len_o        = 8'h00;
  assign outport_addr_o       = addr_r;
  assign outport_write_data_o = wdata_r;

endmodule
